// File: rtl/calc_key_entry.sv
// Operand-entry front end for the 7-bit calculator ALU: builds two decimal
// operands from keypad events, latches the operator and hands off under valid/ready.
module calc_key_entry #(
   parameter int DIGITS = 2,
   parameter int MAXVAL = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [4:0] key_code,
   output logic       key_ready,
   output logic [6:0] inA,
   output logic [6:0] inB,
   output logic [2:0] Sel,
   output logic       req_valid,
   input  logic       req_ready,
   output logic [6:0] entry_val,
   output logic       err_ovf,
   output logic       err_op
);

   // state  | meaning
   // S_A    | entering operand A
   // S_B    | entering operand B (operator latched)
   // S_REQ  | operands presented to ALU, waiting for req_ready
   // S_DONE | result showing; digit starts a new calculation
   typedef enum logic [1:0] {S_A, S_B, S_REQ, S_DONE} state_t;

   localparam int CW = (DIGITS < 1) ? 1 : $clog2(DIGITS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
   localparam logic [10:0]   VAL_MAX = 11'(MAXVAL);

   state_t        state, state_nxt;
   logic [6:0]    a_q, a_nxt;
   logic [6:0]    b_q, b_nxt;
   logic [2:0]    sel_q, sel_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          ovf_q, ovf_nxt;
   logic          errop_q, errop_nxt;

   logic          take;
   logic          k_digit, k_op, k_eq, k_clr, k_bs;
   logic [6:0]    cur_val, base_val, bs_val;
   logic [CW-1:0] base_cnt;
   logic [10:0]   cand;
   logic          dig_ok;
   logic          eq_err, eq_go;

   assign take    = key_valid & key_ready;
   assign k_digit = take && (key_code < 5'd10);
   // 101 and 110 have no ALU function, so those operator codes are dropped
   assign k_op    = take && (key_code[4:3] == 2'b10) &&
                    (key_code[2:0] != 3'b101) && (key_code[2:0] != 3'b110);
   assign k_eq    = take && (key_code == 5'd24);
   assign k_clr   = take && (key_code == 5'd25);
   assign k_bs    = take && (key_code == 5'd26);

   assign cur_val  = (state == S_B) ? b_q : a_q;
   assign base_val = (state == S_DONE) ? 7'd0 : cur_val;
   assign base_cnt = (state == S_DONE) ? '0 : cnt_q;
   assign cand     = ({4'd0, base_val} * 11'd10) + {7'd0, key_code[3:0]};
   assign dig_ok   = (base_cnt < CNT_MAX) && (cand <= VAL_MAX);
   assign bs_val   = cur_val / 7'd10;

   // divide/modulo by zero, and 10^A beyond 15 bits, are refused up front
   assign eq_err = (((sel_q == 3'b010) || (sel_q == 3'b100)) && (b_q == 7'd0)) ||
                   ((sel_q == 3'b111) && (a_q > 7'd4));
   assign eq_go  = (sel_q == 3'b111) || (cnt_q != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         errop_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         a_q     <= a_nxt;
         b_q     <= b_nxt;
         sel_q   <= sel_nxt;
         cnt_q   <= cnt_nxt;
         ovf_q   <= ovf_nxt;
         errop_q <= errop_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      a_nxt     = a_q;
      b_nxt     = b_q;
      sel_nxt   = sel_q;
      cnt_nxt   = cnt_q;
      ovf_nxt   = 1'b0;
      errop_nxt = errop_q;
      if (k_clr) begin
         state_nxt = S_A;
         a_nxt     = '0;
         b_nxt     = '0;
         sel_nxt   = '0;
         cnt_nxt   = '0;
         errop_nxt = 1'b0;
      end else begin
         case (state)
            S_A: begin
               if (k_digit) begin
                  if (dig_ok) begin
                     a_nxt   = cand[6:0];
                     cnt_nxt = cnt_q + CW'(1);
                  end else begin
                     ovf_nxt = 1'b1;
                  end
               end else if (k_bs) begin
                  if (cnt_q != '0) begin
                     a_nxt   = bs_val;
                     cnt_nxt = cnt_q - CW'(1);
                  end
               end else if (k_op) begin
                  sel_nxt   = key_code[2:0];
                  b_nxt     = '0;
                  cnt_nxt   = '0;
                  state_nxt = S_B;
               end
            end
            S_B: begin
               if (k_digit) begin
                  if (dig_ok) begin
                     b_nxt   = cand[6:0];
                     cnt_nxt = cnt_q + CW'(1);
                  end else begin
                     ovf_nxt = 1'b1;
                  end
               end else if (k_bs) begin
                  if (cnt_q != '0) begin
                     b_nxt   = bs_val;
                     cnt_nxt = cnt_q - CW'(1);
                  end
               end else if (k_op) begin
                  if (cnt_q == '0) sel_nxt = key_code[2:0];
               end else if (k_eq) begin
                  if (eq_err)     errop_nxt = 1'b1;
                  else if (eq_go) state_nxt = S_REQ;
               end
            end
            S_REQ: begin
               if (req_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
               if (k_digit) begin
                  if (dig_ok) begin
                     a_nxt     = cand[6:0];
                     b_nxt     = '0;
                     cnt_nxt   = CW'(1);
                     state_nxt = S_A;
                  end else begin
                     ovf_nxt = 1'b1;
                  end
               end
            end
            default: state_nxt = S_A;
         endcase
      end
   end

   // req_valid decodes straight from state so an async reset drops it at once
   always_comb begin
      key_ready = 1'b1;
      req_valid = 1'b0;
      entry_val = b_q;
      case (state)
         S_A:   entry_val = a_q;
         S_REQ: begin
            key_ready = 1'b0;
            req_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign inA     = a_q;
   assign inB     = b_q;
   assign Sel     = sel_q;
   assign err_ovf = ovf_q;
   assign err_op  = errop_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Self-checking bench for calc_key_entry: directed key sequences with a
// request scoreboard popped on each ALU handshake.
module tb_calc_key_entry;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic [4:0] key_code = '0;
   logic       req_ready = 1'b0;
   logic       key_ready, req_valid, err_ovf, err_op;
   logic [6:0] inA, inB, entry_val;
   logic [2:0] Sel;

   logic       en50 = 1'b0;
   logic       kv50;
   logic       one = 1'b1;
   logic       key_ready50, req_valid50, err_ovf50, err_op50;
   logic [6:0] inA50, inB50, entry_val50;
   logic [2:0] Sel50;

   typedef struct {
      int a;
      int b;
      int s;
   } req_t;
   req_t sb[$];

   int total = 0;
   int bad = 0;
   int xfers = 0;
   int x0;

   always #5 clk = ~clk;
   assign kv50 = key_valid & en50;

   calc_key_entry dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .inA(inA), .inB(inB), .Sel(Sel),
      .req_valid(req_valid), .req_ready(req_ready), .entry_val(entry_val),
      .err_ovf(err_ovf), .err_op(err_op)
   );

   calc_key_entry #(.DIGITS(2), .MAXVAL(50)) dut50 (
      .clk(clk), .rst(rst), .key_valid(kv50), .key_code(key_code),
      .key_ready(key_ready50), .inA(inA50), .inB(inB50), .Sel(Sel50),
      .req_valid(req_valid50), .req_ready(one), .entry_val(entry_val50),
      .err_ovf(err_ovf50), .err_op(err_op50)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // called at a falling edge; leaves the key applied for exactly one rising edge
   task automatic press(input logic [4:0] c);
      key_code  = c;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic push_req(input int a, input int b, input int s);
      req_t r;
      r.a = a;
      r.b = b;
      r.s = s;
      sb.push_back(r);
   endtask

   always @(negedge clk) begin
      #1;
      if (rst && req_valid && req_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_req", 1, 0);
         end else begin
            req_t e;
            e = sb.pop_front();
            chk("sb_inA", int'(inA), e.a);
            chk("sb_inB", int'(inB), e.b);
            chk("sb_Sel", int'(Sel), e.s);
         end
         xfers++;
      end
   end

   initial begin
      #1 rst = 1'b0;
      #10;
      chk("rst_req_valid", int'(req_valid), 0);
      chk("rst_inA", int'(inA), 0);
      chk("rst_inB", int'(inB), 0);
      chk("rst_Sel", int'(Sel), 0);
      chk("rst_entry", int'(entry_val), 0);
      chk("rst_err_ovf", int'(err_ovf), 0);
      chk("rst_err_op", int'(err_op), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_key_ready", int'(key_ready), 1);

      // basic 42 + 15
      req_ready = 1'b1;
      press(5'd4);
      press(5'd2);
      chk("a_42", int'(entry_val), 42);
      press(5'd16);
      chk("op_entry_b0", int'(entry_val), 0);
      press(5'd1);
      press(5'd5);
      chk("b_15", int'(entry_val), 15);
      push_req(42, 15, 0);
      press(5'd24);
      chk("eq_req_valid", int'(req_valid), 1);
      chk("eq_key_ready", int'(key_ready), 0);
      chk("eq_inA", int'(inA), 42);
      chk("eq_inB", int'(inB), 15);
      @(negedge clk);
      chk("done_req_low", int'(req_valid), 0);
      chk("done_key_ready", int'(key_ready), 1);
      chk("done_entry_b", int'(entry_val), 15);

      // overflow: 9,9,7,7 from S_DONE
      press(5'd9);
      chk("new_a_9", int'(entry_val), 9);
      chk("new_b_0", int'(inB), 0);
      press(5'd9);
      chk("ovf_none", int'(err_ovf), 0);
      press(5'd7);
      chk("ovf_pulse1", int'(err_ovf), 1);
      chk("ovf_a_99", int'(entry_val), 99);
      press(5'd7);
      chk("ovf_pulse2", int'(err_ovf), 1);
      @(negedge clk);
      chk("ovf_clear", int'(err_ovf), 0);
      chk("ovf_a_still", int'(inA), 99);
      press(5'd25);

      // MAXVAL=50 instance: 6 then 0 -> 60 rejected
      en50 = 1'b1;
      press(5'd6);
      press(5'd0);
      chk("m50_ovf", int'(err_ovf50), 1);
      chk("m50_a_6", int'(entry_val50), 6);
      en50 = 1'b0;
      chk("m99_a_60", int'(entry_val), 60);
      press(5'd25);

      // divide by zero style error
      press(5'd8);
      press(5'd18);
      press(5'd0);
      press(5'd24);
      chk("div0_err_op", int'(err_op), 1);
      chk("div0_no_req", int'(req_valid), 0);
      @(negedge clk);
      chk("err_op_sticky", int'(err_op), 1);
      press(5'd25);
      chk("clr_err_op", int'(err_op), 0);
      chk("clr_inA", int'(inA), 0);
      chk("clr_Sel", int'(Sel), 0);
      press(5'd3);
      chk("clr_state_a", int'(entry_val), 3);
      press(5'd25);

      // power op: A=5 refused, A=4 with empty B accepted
      press(5'd5);
      press(5'd23);
      press(5'd24);
      chk("pow5_err_op", int'(err_op), 1);
      chk("pow5_no_req", int'(req_valid), 0);
      press(5'd25);
      press(5'd4);
      press(5'd23);
      press(5'd21);
      chk("illegal_op_ign", int'(Sel), 7);
      push_req(4, 0, 7);
      press(5'd24);
      chk("pow4_req", int'(req_valid), 1);
      chk("pow4_Sel", int'(Sel), 7);
      chk("pow4_err_op", int'(err_op), 0);
      @(negedge clk);
      chk("pow4_done", int'(req_valid), 0);

      // backpressure: hold req_ready low for 5 cycles of key presses
      press(5'd25);
      req_ready = 1'b0;
      press(5'd1);
      press(5'd17);
      press(5'd2);
      push_req(1, 2, 1);
      press(5'd24);
      for (int i = 0; i < 5; i++) begin
         press(5'd7);
         chk("hold_valid", int'(req_valid), 1);
         chk("hold_key_ready", int'(key_ready), 0);
         chk("hold_inA", int'(inA), 1);
         chk("hold_inB", int'(inB), 2);
         chk("hold_Sel", int'(Sel), 1);
      end
      x0 = xfers;
      req_ready = 1'b1;
      key_code  = 5'd5;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      chk("xfer_valid_low", int'(req_valid), 0);
      chk("xfer_key_ready", int'(key_ready), 1);
      chk("xfer_key_dropped", int'(entry_val), 2);
      chk("xfer_count", xfers - x0, 1);

      // reset in the middle of a request
      press(5'd3);
      press(5'd17);
      press(5'd4);
      req_ready = 1'b0;
      press(5'd24);
      chk("pre_rst_valid", int'(req_valid), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_valid", int'(req_valid), 0);
      @(negedge clk);
      rst = 1'b1;
      chk("post_rst_entry", int'(entry_val), 0);
      chk("post_rst_inA", int'(inA), 0);
      chk("post_rst_inB", int'(inB), 0);
      chk("post_rst_Sel", int'(Sel), 0);
      chk("post_rst_kr", int'(key_ready), 1);

      // backspace
      press(5'd3);
      press(5'd7);
      chk("bs_37", int'(entry_val), 37);
      press(5'd26);
      chk("bs_3", int'(entry_val), 3);
      press(5'd26);
      chk("bs_0", int'(entry_val), 0);
      press(5'd26);
      chk("bs_empty", int'(entry_val), 0);
      press(5'd5);
      chk("bs_cnt_ok", int'(entry_val), 5);
      chk("bs_no_ovf", int'(err_ovf), 0);

      @(negedge clk);
      chk("sb_left", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/calc_key_entry.md
# calc_key_entry

Operand-entry front end for the 7-bit calculator ALU. It accepts decoded keypad events, builds two decimal operands digit by digit, and latches the operator. It then presents `inA`/`inB`/`Sel` to the ALU under a valid/ready handshake. It also provides the value currently being edited, for the operand digit displays, and flags entry errors.

## Interface
Parameters:
- `DIGITS`, default 2: maximum decimal digits per operand.
- `MAXVAL`, default 99: largest operand value accepted; must be ≤ 127.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `key_valid`, in, 1: `key_code` holds one key event this cycle.
- `key_code`, in, 5: 0–9 = digit; 16–23 = operator, with `key_code[2:0]` as the ALU Sel code; 24 = equals; 25 = clear; 26 = backspace; all other codes are ignored.
- `key_ready`, out, 1: key is accepted when `key_valid & key_ready`.
- `inA`, out, 7: operand A to ALU.
- `inB`, out, 7: operand B to ALU.
- `Sel`, out, 3: operation code to ALU.
- `req_valid`, out, 1: operands/Sel valid, held until accepted.
- `req_ready`, in, 1: ALU accepts; transfer on `req_valid & req_ready`.
- `entry_val`, out, 7: value being edited; drives the operand display.
- `err_ovf`, out, 1: one-cycle pulse when a digit is rejected.
- `err_op`, out, 1: sticky; set on an illegal request and cleared by the clear key or reset.

## Operation
States: `S_A` (enter A), `S_B` (enter B), `S_REQ` (handshake), `S_DONE` (result showing).

Reset (async, `rst`=0):
- State goes to `S_A`.
- `inA`, `inB`, `Sel`, `entry_val`, the digit count, `req_valid`, `err_ovf` and `err_op` all go to 0.
- `key_ready` is 1 once reset is released.

Digit d (`S_A`, `S_B`):
- Candidate value = val*10 + d.
- Accept only if count < DIGITS and candidate ≤ MAXVAL; on accept, val and count update.
- Otherwise val is unchanged and `err_ovf` pulses.
- A leading 0 counts as a digit.

Backspace (`S_A`, `S_B`):
- If count > 0: val = val/10 and count decrements.
- If count = 0: no effect.

Operator key:
- Codes 101 and 110 have no ALU function and are ignored in every state.
- In `S_A`: latch Sel, go to `S_B` with B=0 and count=0. A may be empty, giving A=0.
- In `S_B` with count=0: Sel is replaced.
- In `S_B` with count>0: ignored.

Equals in `S_B`:
- Sel 010 or 100 with B=0: set `err_op`, stay in `S_B`.
- Sel 111 with A>4: set `err_op`, stay in `S_B`. The ALU result 10^A must fit 15 bits; B is unused and count=0 is allowed.
- Other Sel with count=0: ignored.
- Otherwise: go to `S_REQ`.

Equals in `S_A`: ignored.

`S_REQ`:
- `req_valid`=1 and `key_ready`=0.
- `inA`, `inB` and `Sel` are frozen.
- On transfer: go to `S_DONE` and drop `req_valid` the next cycle.

`S_DONE`:
- Digit: A and B cleared to 0, A starts with that digit, go to `S_A`.
- Clear: go to `S_A`.
- Other keys: ignored.

Clear (any state except `S_REQ`): A, B, Sel, count and `err_op` go to 0; go to `S_A`.

`entry_val`: shows A in `S_A` and B in `S_B`/`S_REQ`/`S_DONE`.

## Timing
- A key is sampled on the rising edge where `key_valid & key_ready`; all register and output effects are visible the following cycle.
- Accepted equals → `req_valid`=1 on the next cycle, a latency of 1.
- Minimum `req_valid` high time is 1 cycle, when `req_ready` is already high.
- `req_valid` stays high with stable data for as long as `req_ready`=0. There is no timeout and no withdrawal.
- Transfer cycle: `key_ready` is still 0, so a key presented in that same cycle is dropped. The source must hold or retry.
- `key_ready` returns to 1 on the cycle after transfer.
- Reset asserted during `S_REQ`: `req_valid` falls immediately (asynchronously). No transfer is implied.
- `err_ovf` is high exactly one cycle per rejected digit. Back-to-back rejections give consecutive pulses.
- Keys arriving every cycle must each be processed; there is no dead cycle except in `S_REQ`.

## Test plan
- Reset, then digits 4, 2, operator 16, digits 1, 5, equals, with `req_ready`=1 → next cycle `req_valid`=1, `inA`=42, `inB`=15, `Sel`=000; then `S_DONE`.
- In `S_A` enter 9, 9, 7 → `err_ovf` pulses once, A stays 99. With MAXVAL=50: 6, 0 → second digit rejected, A=6.
- A=8, op 010, B=0 with count 1, equals → `err_op`=1, no `req_valid`. Clear → `err_op`=0, state `S_A`, A=0.
- op 111 with A=5, equals → `err_op`=1. Same sequence with A=4 and B empty, equals → request with `inA`=4, `Sel`=111.
- Hold `req_ready`=0 for 5 cycles while pressing keys → `req_valid` stays 1, operands unchanged, keys dropped. Release `req_ready` → one transfer, `req_valid` low next cycle.
- Assert `rst` mid-`S_REQ` → `req_valid` low within the same cycle. After release, state `S_A` with all outputs 0. Backspace on 37 → 3, then → 0, further backspace has no effect.
